// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, opcodes, mux selects, ALU codes.
// Pure declarations; no timing of its own.
// No flow control involved.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_of(input logic [6:0] opcode);
        case (opcode)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps ALUOp plus instruction function bits to the ALU operation code.
// Purely combinational, zero latency.
// No flow control involved.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op5=1) with funct7b5 set is a subtract; addi ignores bit 30
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b111:  alu_control = ALU_AND;
                    3'b110:  alu_control = ALU_OR;
                    3'b100:  alu_control = ALU_XOR;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a multicycle RV32 subset datapath (lw, sw, R, I-ALU, beq, jal).
// beq 3 cycles; R/I/jal/sw 4; lw 5, plus one cycle per mem_ready-low cycle in FETCH/MEMREAD/MEMWRITE.
// Stalls by holding state while mem_ready is low in memory-access states.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal,
    output logic [3:0] state
);

    state_t     state_q;
    state_t     cur_state;
    state_t     state_next;
    logic [1:0] alu_op;
    logic       branch;
    logic       pc_update;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_next;
        end
    end

    // Outputs already show FETCH behaviour during the reset cycle itself
    assign cur_state = reset ? S_FETCH : state_q;

    always_comb begin
        state_next = S_FETCH;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RD2;
        RegWrite   = 1'b0;
        alu_op     = ALUOP_ADD;
        branch     = 1'b0;
        pc_update  = 1'b0;
        illegal    = 1'b0;
        case (cur_state)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    pc_update  = 1'b1;
                    state_next = S_DECODE;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECR;
                    OP_I:         state_next = S_EXECI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
                    default: begin
                        illegal    = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                if (op == OP_LW) begin
                    state_next = S_MEMREAD;
                end else if (op == OP_SW) begin
                    state_next = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                AdrSrc     = 1'b1;
                state_next = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                state_next = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_RD1;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = SRCA_RD1;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                pc_update  = 1'b1;
                state_next = S_ALUWB;
            end
            default: state_next = S_FETCH;
        endcase
    end

    assign PCWrite = (branch & Zero) | pc_update;
    assign ImmSrc  = imm_src_of(op);
    assign state   = cur_state;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: stimulus pushes the expected per-cycle control word, a negedge monitor pops and compares.
// Expectations come from an instruction-level model of phases, latencies and output tables.
module tb_multicycle_controller;

    typedef enum int {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                      P_EXECR, P_EXECI, P_ALUWB, P_BEQ, P_JAL} ph_e;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic [1:0] res;
        logic [1:0] sa;
        logic [1:0] sb;
        logic       rw;
        logic [1:0] imm;
        logic [2:0] alu;
        logic       ill;
    } obs_t;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    obs_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc;
    int    rst_at;
    bit    aborted;
    int    zero_mode;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .RegWrite   (RegWrite),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .illegal    (illegal),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_legal(input logic [6:0] o);
        return (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
               (o == 7'b0010011) || (o == 7'b1100011) || (o == 7'b1101111);
    endfunction

    function automatic logic [1:0] imm_ref(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] alu_ref(input logic [1:0] aluop, input logic [2:0] f3,
                                           input logic f7, input logic op5);
        if (aluop == 2'b01) return 3'b001;
        if (aluop != 2'b10) return 3'b000;
        if (f3 == 3'b000) return (op5 && f7) ? 3'b001 : 3'b000;
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b111) return 3'b010;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b100) return 3'b100;
        return 3'b000;
    endfunction

    // Expected control word for one cycle spent in phase ph with the given inputs
    function automatic obs_t model(input ph_e ph, input logic [6:0] o, input logic [2:0] f3,
                                   input logic f7, input logic z, input logic mr);
        obs_t       e;
        logic [1:0] aluop;
        e     = '0;
        aluop = 2'b00;
        e.st  = 4'(int'(ph));
        e.imm = imm_ref(o);
        case (ph)
            P_FETCH:    begin e.sb = 2'b10; e.res = 2'b10; e.irw = mr; e.pcw = mr; end
            P_DECODE:   begin e.sa = 2'b01; e.sb = 2'b01; e.ill = !is_legal(o); end
            P_MEMADR:   begin e.sa = 2'b10; e.sb = 2'b01; end
            P_MEMREAD:  e.adr = 1'b1;
            P_MEMWB:    begin e.res = 2'b01; e.rw = 1'b1; end
            P_MEMWRITE: begin e.adr = 1'b1; e.mw = 1'b1; end
            P_EXECR:    begin e.sa = 2'b10; aluop = 2'b10; end
            P_EXECI:    begin e.sa = 2'b10; e.sb = 2'b01; aluop = 2'b10; end
            P_ALUWB:    e.rw = 1'b1;
            P_BEQ:      begin e.sa = 2'b10; aluop = 2'b01; e.pcw = z; end
            P_JAL:      begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
            default:    e = '0;
        endcase
        e.alu = alu_ref(aluop, f3, f7, o[5]);
        return e;
    endfunction

    task automatic step(input ph_e ph, input logic mr);
        obs_t e;
        mem_ready = mr;
        Zero = (zero_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(zero_mode);
        if (cyc == rst_at) begin
            reset   = 1'b1;
            aborted = 1'b1;
            e = model(P_FETCH, op, funct3, funct7b5, Zero, mr);
            tag_q.push_back("reset_cycle");
        end else begin
            reset = 1'b0;
            e = model(ph, op, funct3, funct7b5, Zero, mr);
            tag_q.push_back(ph.name());
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_phase(input ph_e ph, input int stalls);
        for (int i = 0; i < stalls; i++) begin
            step(ph, 1'b0);
            if (aborted) return;
        end
        step(ph, 1'b1);
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int fstall, input int mstall, input int rst_cycle);
        logic mr;
        cyc = 0; aborted = 0; rst_at = rst_cycle;
        op = o; funct3 = f3; funct7b5 = f7;
        wait_phase(P_FETCH, fstall);
        if (aborted) return;
        mr = 1'($urandom_range(0, 1));
        step(P_DECODE, mr);
        if (aborted || !is_legal(o)) return;
        mr = 1'($urandom_range(0, 1));
        case (o)
            7'b0000011: begin
                step(P_MEMADR, mr);
                if (aborted) return;
                wait_phase(P_MEMREAD, mstall);
                if (aborted) return;
                step(P_MEMWB, mr);
            end
            7'b0100011: begin
                step(P_MEMADR, mr);
                if (aborted) return;
                wait_phase(P_MEMWRITE, mstall);
            end
            7'b0110011, 7'b0010011: begin
                step((o == 7'b0110011) ? P_EXECR : P_EXECI, mr);
                if (aborted) return;
                step(P_ALUWB, mr);
            end
            7'b1100011: step(P_BEQ, mr);
            default: begin
                step(P_JAL, mr);
                if (aborted) return;
                step(P_ALUWB, mr);
            end
        endcase
    endtask

    // Monitor: one expected word per cycle, compared mid-cycle
    initial begin
        obs_t  a;
        obs_t  e;
        string t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                     RegWrite, ImmSrc, ALUControl, illegal};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h (state %0d vs %0d)", t, a, e, a.st, e.st);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] legal_ops [6];
        logic [6:0] o;
        int         k;
        legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
        reset = 1'b1; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
        Zero = 1'b0; mem_ready = 1'b0; zero_mode = 2;
        @(posedge clk);
        #1;
        // Held reset: FETCH outputs with PCWrite/IRWrite following mem_ready
        cyc = 0;
        for (int i = 0; i < 3; i++) begin
            rst_at = cyc;
            step(P_FETCH, 1'(i));
        end
        run_instr(7'b0110011, 3'b000, 1'b1, 0, 0, -1);
        run_instr(7'b0000011, 3'b010, 1'b0, 0, 3, -1);
        zero_mode = 1;
        run_instr(7'b1100011, 3'b000, 1'b0, 0, 0, -1);
        zero_mode = 0;
        run_instr(7'b1100011, 3'b000, 1'b0, 1, 0, -1);
        zero_mode = 2;
        run_instr(7'b0100011, 3'b010, 1'b0, 0, 2, -1);
        run_instr(7'b1111111, 3'b000, 1'b0, 0, 0, -1);
        // Reset landing in a MEMWRITE stall cycle
        run_instr(7'b0100011, 3'b010, 1'b0, 0, 3, 4);
        run_instr(7'b0010011, 3'b000, 1'b1, 2, 0, -1);
        for (int n = 0; n < 250; n++) begin
            k = $urandom_range(0, 7);
            if (k < 6) o = legal_ops[k];
            else if (k == 6) o = 7'($urandom);
            else o = 7'b1111111;
            run_instr(o, 3'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                      $urandom_range(0, 3), ($urandom_range(0, 9) == 0) ? $urandom_range(0, 6) : -1);
        end
        rst_at = -1;
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have one clock and synchronous, active-high reset: clk input 1 (rising edge); reset input 1 (synchronous, active-high).
REQ-002 SHALL have the following ports, one per line as name / direction / width / meaning:
- op input 7: instruction opcode (Instr[6:0]).
- funct3 input 3: Instr[14:12].
- funct7b5 input 1: Instr[30].
- Zero input 1: ALU zero flag.
- mem_ready input 1: memory access completes this cycle.
- PCWrite output 1: PC register enable.
- AdrSrc output 1: 0 = PC, 1 = ALUOut to memory address.
- MemWrite output 1: memory write request.
- IRWrite output 1: instruction/OldPC register enable.
- ResultSrc output 2: 00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA output 2: 00 PC, 01 OldPC, 10 RD1.
- ALUSrcB output 2: 00 RD2, 01 ImmExt, 10 constant 4.
- RegWrite output 1: register file write enable.
- ImmSrc output 2: immediate format select.
- ALUControl output 3: ALU operation code.
- illegal output 1: one-cycle pulse on unsupported opcode.
- state output 4: current FSM state, for debug.

Function
REQ-003 SHALL implement a Moore FSM with encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10; codes 11-15 SHALL go to FETCH next cycle.
REQ-004 SHALL use these opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
REQ-005 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. While mem_ready=0, SHALL stay in FETCH with IRWrite=PCWrite=0. When mem_ready=1, SHALL assert IRWrite=1 and PCUpdate=1, then go to DECODE.
REQ-006 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target). Next state: lw/sw -> MEMADR; R -> EXECR; I-ALU -> EXECI; beq -> BEQ; jal -> JAL. Any other opcode -> FETCH, with illegal=1 for that cycle.
REQ-007 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state: MEMREAD if op=lw, MEMWRITE if op=sw.
REQ-008 MEMREAD: AdrSrc=1, ResultSrc=00. SHALL hold until mem_ready=1, then go to MEMWB.
REQ-009 MEMWB: ResultSrc=01, RegWrite=1, then go to FETCH.
REQ-010 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held level-high until mem_ready=1, then go to FETCH.
REQ-011 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then go to ALUWB. EXECI: same except ALUSrcB=01, then go to ALUWB.
REQ-012 ALUWB: ResultSrc=00, RegWrite=1, then go to FETCH.
REQ-013 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, then go to FETCH.
REQ-014 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1, then go to ALUWB.
REQ-015 SHALL drive PCWrite = (Branch & Zero) | PCUpdate, combinationally from the current state and Zero.
REQ-016 SHALL decode ImmSrc combinationally from op alone: lw/I-ALU 00, sw 01, beq 10, jal 11, others 00.
REQ-017 SHALL derive ALUControl from ALUOp, funct3, funct7b5 and op[5]:
- ALUOp 00 -> 000 (add); ALUOp 01 -> 001 (sub).
- ALUOp 10: funct3 000 gives sub (001) if {op[5],funct7b5}=11, else add (000).
- ALUOp 10: funct3 010 -> 101, 111 -> 010, 110 -> 011, 100 -> 100.
- ALUOp 10 with any other funct3, and ALUOp 11, -> 000.
REQ-018 All outputs not listed for a state SHALL be 0. Outputs SHALL be glitch-free functions of state (plus Zero/mem_ready where stated).
REQ-019 Instruction latencies with mem_ready tied high: beq 3 cycles; R, I-ALU, jal, sw 4; lw 5.

Reset
REQ-020 reset=1 at a clock edge SHALL force state to FETCH, overriding any transition, including during a mem_ready stall or mid-instruction.
REQ-021 While in reset, and in the first cycle after, every output SHALL take its FETCH value: PCWrite/IRWrite gated by mem_ready, MemWrite=RegWrite=illegal=0, state=0.

Structure
REQ-022 State encodings, opcode constants and ALUOp/ALUControl codes SHALL live in a shared package (riscv_ctrl_pkg).
REQ-023 ALUControl decoding SHALL be done in one sub-module instance (alu_decoder); the FSM and output logic SHALL be in the top module.

Verification
REQ-024 Reset then `add` (op 0110011, funct7b5=1, funct3 000, mem_ready=1): states 0,1,6,8,0. In EXECR, ALUControl=001. RegWrite=1 only in ALUWB.
REQ-025 `lw` with mem_ready=0 for 3 cycles in MEMREAD: state remains 3 for 3 cycles, and MEMWB is entered after the mem_ready=1 cycle. Total 8 cycles.
REQ-026 `beq`: with Zero=1 in BEQ, PCWrite=1; with Zero=0, PCWrite=0. Both cases ALUControl=001, ImmSrc=10.
REQ-027 `sw` with mem_ready low 2 cycles: MemWrite=1 for exactly 3 consecutive cycles in state 5. ImmSrc=01. RegWrite never asserted.
REQ-028 Opcode 1111111 in DECODE: illegal=1 for 1 cycle, next state FETCH, and no RegWrite/MemWrite/PCWrite in that cycle.
REQ-029 reset asserted in MEMWRITE with mem_ready=0: next state 0, and MemWrite=0 from the cycle after the reset edge.
